// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: bus widths and opcode encodings
// used by the fetch stage, the controller and the ALU.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 13;
  localparam int INSN_W = 2 * DATA_W;
  localparam int OPC_W  = INSN_W - ADDR_W;

  localparam logic [OPC_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OPC_W-1:0] OP_XORR = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OPC_W-1:0] OP_STO  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b111;

endpackage

// File: rtl/pc_counter.sv
// Program counter: loadable up-counter, load beats increment, frozen while
// hold is high, cleared synchronously by clear.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              hold,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  // PC register; increment wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      if (load) begin
        count <= load_val;
      end else if (inc) begin
        count <= count + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: assembles the 16-bit IR from two memory bytes,
// owns the PC and the sticky halt flag, and muxes the memory address.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              fetch,
  input  logic [DATA_W-1:0] data,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              halt,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              ir_valid,
  output logic              halted
);

  localparam int IR_W = 2 * DATA_W;

  logic [IR_W-1:0] ir;
  logic            hi_lo;

  // IR byte assembly and halt flag; hi_lo drops whenever load_ir does so a
  // partial fetch can never shift the next instruction by one byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      hi_lo    <= 1'b0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (!ena) begin
      ir       <= '0;
      hi_lo    <= 1'b0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (halt) begin
        halted <= 1'b1;
      end
      if (!halted) begin
        if (load_ir) begin
          if (!hi_lo) begin
            ir[IR_W-1:DATA_W] <= data;
            hi_lo             <= 1'b1;
            ir_valid          <= 1'b0;
          end else begin
            ir[DATA_W-1:0] <= data;
            hi_lo          <= 1'b0;
            ir_valid       <= 1'b1;
          end
        end else begin
          hi_lo <= 1'b0;
        end
      end
    end
  end

  assign opcode  = ir[IR_W-1:ADDR_W];
  assign ir_addr = ir[ADDR_W-1:0];

  // The halt edge itself still updates PC; freezing starts one edge later
  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!ena),
    .hold     (halted),
    .load     (load_pc),
    .inc      (inc_pc),
    .load_val (ir_addr),
    .count    (pc_addr)
  );

  // Memory address mux, purely combinational
  always_comb begin
    addr = fetch ? pc_addr : ir_addr;
  end

endmodule
